// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver with frame snapshot and PWM brightness.
// Optional blink support is compiled in with SEG_BLINK_EN (adds blink_in and BLINK_FRAMES).
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS        = 8,
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BRIGHT_W        = 3
`ifdef SEG_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES    = 125
`endif
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [BRIGHT_W-1:0]   bright,
`ifdef SEG_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_in,
`endif
  output logic [N_DIGITS-1:0]   AN,
  output logic [6:0]            display,
  output logic                  DP,
  output logic                  frame_start
);

  localparam int unsigned SEL_W = $clog2(N_DIGITS);
  localparam int unsigned CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int unsigned SUB   = TICKS_PER_DIGIT >> BRIGHT_W;

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICKS_PER_DIGIT - 1);

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    unique case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = 7'b0111111;
      4'd11:   seg = 7'b1000111;
      4'd12:   seg = 7'b0101011;
      4'd13:   seg = 7'b0001001;
      4'd14:   seg = 7'b0011100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Scan counters
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             slot_end, frame_end;

  always_comb begin
    slot_end   = (slot_cnt_q == LastCnt);
    frame_end  = slot_end && (sel_q == LastSel);
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
    sel_d      = sel_q;
    if (slot_end) begin
      sel_d = (sel_q == LastSel) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      slot_cnt_q <= '0;
      sel_q      <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      sel_q      <= sel_d;
    end
  end

  // Snapshot taken on the last cycle of a frame so the next frame is coherent
  logic [3:0]          code_q [N_DIGITS];
  logic [N_DIGITS-1:0] dp_q;
  logic [N_DIGITS-1:0] blank_q;
  logic [BRIGHT_W-1:0] bright_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        code_q[i] <= 4'hF;
      end
      dp_q     <= '0;
      blank_q  <= '1;
      bright_q <= '0;
    end else if (frame_end) begin
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        code_q[i] <= digits_in[4*i +: 4];
      end
      dp_q     <= dp_in;
      blank_q  <= blank_in;
      bright_q <= bright;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] LastFrame = FR_W'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] blink_q;
  logic [FR_W-1:0]     frame_cnt_q;
  logic                phase_on_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      blink_q     <= '0;
      frame_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (frame_end) begin
      blink_q <= blink_in;
      if (frame_cnt_q == LastFrame) begin
        frame_cnt_q <= '0;
        phase_on_q  <= ~phase_on_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  logic dark;
  assign dark = blank_q[sel_q] | (blink_q[sel_q] & ~phase_on_q);
`else
  logic dark;
  assign dark = blank_q[sel_q];
`endif

  // Output stage: one cycle behind the counters
  logic [31:0]         on_limit;
  logic                lit;
  logic [N_DIGITS-1:0] an_d;
  logic [6:0]          display_d;
  logic                dp_d;
  logic                frame_start_d;

  always_comb begin
    on_limit      = (32'(bright_q) + 32'd1) * SUB;
    lit           = !dark && (32'(slot_cnt_q) < on_limit);
    an_d          = '1;
    display_d     = 7'b1111111;
    dp_d          = 1'b1;
    frame_start_d = (sel_q == '0) && (slot_cnt_q == '0);
    if (lit) begin
      an_d[sel_q] = 1'b0;
      display_d   = glyph(code_q[sel_q]);
      dp_d        = ~dp_q[sel_q];
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      AN          <= '1;
      display     <= 7'b1111111;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      AN          <= an_d;
      display     <= display_d;
      DP          <= dp_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-level reference model queues expected outputs, a monitor compares.
module tb_seg7_scan_driver;
  localparam int N     = 4;
  localparam int T     = 8;
  localparam int BW    = 2;
  localparam int SUB   = T >> BW;
  localparam int FRAME = N * T;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits;
  logic [3:0]    dp, blank;
  logic [1:0]    bright;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp_o, fs;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS       (N),
    .TICKS_PER_DIGIT(T),
    .BRIGHT_W       (BW)
  ) dut (
    .clk_100MHz (clk),
    .reset      (rst),
    .digits_in  (digits),
    .dp_in      (dp),
    .blank_in   (blank),
    .bright     (bright),
    .AN         (an),
    .display    (seg),
    .DP         (dp_o),
    .frame_start(fs)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b1000111,
    7'b0101011, 7'b0001001, 7'b0011100, 7'b1111111};

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   k = 0;        // output cycles since reset release
  int   cyc = 0;

  // Frame view held by the model: what the display shows during the current frame
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_blank;
  logic [1:0]  m_bright;

  always @(posedge clk) begin : model
    exp_t e;
    int   pos, dig, slot;
    cyc++;
    if (rst) begin
      k        = 0;
      m_digits = 16'hFFFF;
      m_blank  = 4'hF;
      m_dp     = 4'h0;
      m_bright = 2'd0;
      e        = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
    end else begin
      k++;
      pos  = (k - 1) % FRAME;
      dig  = pos / T;
      slot = pos % T;
      e    = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: (pos == 0)};
      if (!m_blank[dig] && slot < (int'(m_bright) + 1) * SUB) begin
        e.an[dig] = 1'b0;
        e.seg     = glyph_tab[m_digits[dig*4 +: 4]];
        e.dp      = ~m_dp[dig];
      end
      if (pos == FRAME - 1) begin
        m_digits = digits;
        m_dp     = dp;
        m_blank  = blank;
        m_bright = bright;
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{an: an, seg: seg, dp: dp_o, fs: fs};
      checks++;
      if (a !== e)
        $display("FAIL outputs cyc%0d: got AN=%b seg=%b DP=%b fs=%b, want AN=%b seg=%b DP=%b fs=%b",
                 cyc, a.an, a.seg, a.dp, a.fs, e.an, e.seg, e.dp, e.fs);
      else
        passes++;
      checks++;
      if ($countones(~an) > 1)
        $display("FAIL onehot cyc%0d: got AN=%b, want at most one low bit", cyc, an);
      else
        passes++;
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the display is showing digit d, bounded to two frames
  task automatic wait_digit(input int d);
    int n;
    n = 0;
    while (!(k > 0 && ((k - 1) % FRAME) / T == d) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2 * FRAME)
      $display("FAIL wait_digit%0d: got timeout after %0d cycles, want digit reached", d, n);
    else
      passes++;
  endtask

  initial begin
    rst    = 1'b1;
    digits = 16'h4321;
    dp     = 4'b0000;
    blank  = 4'b0000;
    bright = 2'd3;
    run(5);
    rst = 1'b0;
    run(2 * FRAME);             // dark first frame, then 1 2 3 4

    bright = 2'd0;
    run(2 * FRAME);

    bright = 2'd3;
    run(FRAME);
    wait_digit(1);
    digits = 16'h9999;          // must not appear until next frame
    run(2 * FRAME);

    digits = 16'hEDCB;
    blank  = 4'b0100;
    dp     = 4'b0010;
    run(2 * FRAME);

    wait_digit(2);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3 * FRAME);

    for (int i = 0; i < 8; i++) begin
      digits = 16'($urandom);
      dp     = 4'($urandom);
      blank  = 4'($urandom);
      bright = 2'($urandom);
      run($urandom_range(5, 40));
    end
    run(2 * FRAME);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment driver for the Nexys A7 display, generalising the fixed 8-digit timer/temperature display path. It scans N_DIGITS common-anode digits and decodes a 4-bit glyph code per digit, covering digits plus the mode and degree symbols. It adds frame-coherent input snapshotting, per-digit blanking and decimal point, and PWM brightness control. It sits between the timer/temperature/mode formatting logic and the board AN/segment/DP pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16); SEL_W = clog2(N_DIGITS).
TICKS_PER_DIGIT, 100000, clk cycles per digit slot (1 ms at 100 MHz); must be a multiple of 2**BRIGHT_W.
BRIGHT_W, 3, brightness control width; SUB = TICKS_PER_DIGIT >> BRIGHT_W.

Ports:
clk_100MHz  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
digits_in  input  4*N_DIGITS  glyph code per digit; digit i = bits [4i+3:4i]; digit 0 is the rightmost
dp_in  input  N_DIGITS  1 = decimal point lit on digit i
blank_in  input  N_DIGITS  1 = digit i dark
bright  input  BRIGHT_W  brightness; max value = 100% duty
AN  output  N_DIGITS  anode enables, active-low
display  output  7  segments {g,f,e,d,c,b,a}, active-low
DP  output  1  decimal point, active-low
frame_start  output  1  one-cycle pulse aligned with first output cycle of digit 0

Behaviour:
- Counters
  - slot_cnt counts 0..TICKS_PER_DIGIT-1.
  - At terminal count it returns to 0 and sel increments.
  - sel counts 0..N_DIGITS-1, then wraps to 0. Non-power-of-two N_DIGITS must wrap at N_DIGITS-1.
- Snapshot
  - digits_in, dp_in, blank_in and bright are captured into internal registers on the edge where (sel, slot_cnt) = (N_DIGITS-1, TICKS_PER_DIGIT-1).
  - The whole following frame uses the snapshot. Mid-frame input changes are never visible.
- Outputs are registered with 1-cycle latency from (sel, slot_cnt, snapshot):
  - AN[sel] = 0 iff snapshot blank[sel] = 0 and slot_cnt < (bright_snap+1)*SUB; all other AN bits = 1.
  - display = glyph(code[sel]) when AN[sel] is active, else 7'b1111111.
  - DP = ~dp_snap[sel] when AN[sel] is active, else 1.
  - frame_start = 1 for exactly the cycle in which outputs reflect sel=0, slot_cnt=0, regardless of blanking.
- Glyph table
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001
  - 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000
  - 10 '-': 0111111, 11 'L': 1000111, 12 'n': 0101011, 13 'H': 0001001
  - 14 degree: 0011100, 15 blank: 1111111
- Brightness: bright = 2**BRIGHT_W-1 gives full-slot on. bright = 0 gives on for slot_cnt 0..SUB-1 only. At most one AN bit is low in any cycle.
- Reset
  - While reset is high: slot_cnt=0, sel=0, AN all 1, display=1111111, DP=1, frame_start=0.
  - Snapshot reset values: codes=15, blank all 1, dp all 0, bright=0.
  - Reset mid-frame aborts the scan immediately.
  - The first frame after reset is fully dark. Live data appears from the second frame.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - Adds input blink_in [N_DIGITS-1:0] and parameter BLINK_FRAMES (default 125).
  - blink_in is captured with the other snapshot inputs.
  - A frame counter toggles a blink phase every BLINK_FRAMES frames. The phase is "on" after reset.
  - During the "off" phase, digits with blink_snap=1 behave as blanked. frame_start is unaffected.
- Undefined: no blink_in port, no parameter, no frame counter. Behaviour is exactly as above.

Test Plan:
(Bench params: N_DIGITS=4, TICKS_PER_DIGIT=8, BRIGHT_W=2, so SUB=2 and 32-cycle frames.)
1. Reset for 5 cycles, then release with digits_in=16'h4321 and bright=3 -> AN=1111, display=1111111, DP=1 during reset and the whole first 32-cycle frame; frame_start pulses at cycle 1 after release and every 32 cycles.
2. Continue from 1 -> second frame shows AN=1110/display=1111001 for 8 cycles, then 1101/0100100, 1011/0110000, 0111/0011001; never more than one AN bit low.
3. bright=0 -> each digit's AN bit is low for 2 of its 8 cycles (slot_cnt 0,1) and high for the other 6; display=1111111 while dark.
4. digits_in changed from 16'h4321 to 16'h9999 at sel=1 mid-frame -> the remaining digits of that frame still show 3 and 4; all four digits show 9 (0010000) from the next frame_start.
5. digits_in=16'hEDCB, blank_in=4'b0100, dp_in=4'b0010 -> digit0 1000111, digit1 0101011 with DP=0, digit2 AN stays 1 for its whole slot, digit3 0011100; DP=1 in every other slot.
6. Assert reset for 1 cycle while sel=2 -> next cycle shows reset outputs; scan restarts at sel=0; the following frame is dark; live data resumes one frame later.
